sequential_divider: RTL and testbench

- Iterative restoring divider for the integer unit.
- Consumes a dividend and divisor and produces quotient and remainder, one quotient bit per cycle.
- Divides signed or unsigned operands with RISC-V M-extension semantics (DIV/DIVU/REM/REMU).
- Sits beside fractionned_multiplier in the execute stage and shares its operand and valid conventions.

---
 rtl/sequential_divider.sv | 150 +++++++++++++++
 tb/tb_sequential_divider.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
// Module  : sequential_divider
// Brief   : Iterative restoring divider, one quotient bit per cycle, with
//           RISC-V DIV/DIVU/REM/REMU semantics.
// Revision: 1.0 - initial release
// ============================================================================
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             signed_op,
    input  logic             start,
    output logic [WIDTH-1:0] output_quotient,
    output logic [WIDTH-1:0] output_remainder,
    output logic             output_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ones = '1;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quo_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_valid;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;

    assign w_accept   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_div_zero = (r_b == '0);
    assign w_ovf      = r_signed & (r_a == c_min) & (r_b == c_ones);
    assign w_abs_a    = (r_signed & r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
    assign w_abs_b    = (r_signed & r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;

    // The quotient bits shift into r_dvd as the dividend bits shift out.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_trial[WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_PREP;
            // Special cases pass through FIX with zeroed sign flags.
            S_PREP:  w_state_nxt = (w_div_zero | w_ovf) ? S_FIX : S_ITER;
            S_ITER:  if (r_cnt == c_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_PREP : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_div     <= '0;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_quo_out <= '0;
            r_rem_out <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= input_a;
                r_b      <= input_b;
                r_signed <= signed_op;
            end
            case (r_state)
                S_PREP: begin
                    r_cnt <= '0;
                    r_div <= w_abs_b;
                    if (w_div_zero) begin
                        r_dvd   <= c_ones;
                        r_rem   <= r_a;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else if (w_ovf) begin
                        r_dvd   <= r_a;
                        r_rem   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else begin
                        r_dvd   <= w_abs_a;
                        r_rem   <= '0;
                        r_neg_q <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_neg_r <= r_signed & r_a[WIDTH-1];
                    end
                end
                S_ITER: begin
                    r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quo_out <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
                    r_rem_out <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                end
                default: ;
            endcase
            r_valid <= (w_state_nxt == S_DONE);
        end
    end

    assign output_quotient  = r_quo_out;
    assign output_remainder = r_rem_out;
    assign output_valid     = r_valid;
    assign busy             = (r_state == S_PREP) | (r_state == S_ITER) | (r_state == S_FIX);

endmodule
`default_nettype wire

// File: tb/tb_sequential_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_sequential_divider
// Brief   : Scoreboard bench for sequential_divider with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sequential_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          e0;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        signed_op;
    logic        start;
    logic [31:0] output_quotient;
    logic [31:0] output_remainder;
    logic        output_valid;
    logic        busy;

    exp_t        sb[$];
    int          cyc;
    int          checks;
    int          errors;
    logic        prev_valid;
    logic [31:0] last_q;
    logic [31:0] last_r;

    sequential_divider #(.WIDTH(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .input_a          (input_a),
        .input_b          (input_b),
        .signed_op        (signed_op),
        .start            (start),
        .output_quotient  (output_quotient),
        .output_remainder (output_remainder),
        .output_valid     (output_valid),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every valid pulse.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                chk("pulse_width", {31'd0, output_valid}, 32'd0);
                chk("hold_q", output_quotient, last_q);
                chk("hold_r", output_remainder, last_r);
            end
            if (output_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("quotient", output_quotient, e.q);
                    chk("remainder", output_remainder, e.r);
                    chk("latency", 32'(cyc - e.e0), 32'(e.lat));
                    chk("busy_in_done", {31'd0, busy}, 32'd0);
                    last_q = e.q;
                    last_r = e.r;
                end
            end
            prev_valid = output_valid;
        end
    end

    task automatic push_exp(input logic [31:0] eq, input logic [31:0] er, input int lat);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.lat = lat;
        e.e0  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input int lat);
        @(negedge clock);
        push_exp(eq, er, lat);
        input_a   = a;
        input_b   = b;
        signed_op = s;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        input_a   = $urandom;
        input_b   = $urandom;
        signed_op = ~s;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        logic found;
        checks     = 0;
        errors     = 0;
        prev_valid = 1'b0;
        last_q     = '0;
        last_r     = '0;
        reset_n    = 1'b0;
        start      = 1'b0;
        input_a    = '0;
        input_b    = '0;
        signed_op  = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_q", output_quotient, 32'd0);
        chk("rst_r", output_remainder, 32'd0);
        chk("rst_valid", {31'd0, output_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34);
        wait_done();
        issue(32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        wait_done();
        issue(32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1, 34);
        wait_done();
        issue(32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 2);
        wait_done();
        issue(32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 2);
        wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 2);
        wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 34);
        wait_done();

        // A start pulse mid-iteration must be ignored.
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 34);
        repeat (10) @(negedge clock);
        input_a   = 32'd5;
        input_b   = 32'd5;
        signed_op = 1'b0;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        wait_done();

        // Back-to-back: start held high while the first result is in DONE.
        issue(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 34);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (output_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_first_valid actual=0 required=1");
        end else begin
            push_exp(32'h0FFF_FFFF, 32'hF, 34);
            input_a   = 32'hFFFF_FFFF;
            input_b   = 32'h10;
            signed_op = 1'b0;
            start     = 1'b1;
            @(negedge clock);
            start     = 1'b0;
        end
        wait_done();

        // Reset in the middle of iteration 15: the aborted op must vanish.
        @(negedge clock);
        input_a   = 32'd1000;
        input_b   = 32'd7;
        signed_op = 1'b0;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        repeat (16) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_q", output_quotient, 32'd0);
        chk("midrst_r", output_remainder, 32'd0);
        chk("midrst_valid", {31'd0, output_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
